// File: rtl/kamacore_pkg.sv
// Shared defaults and state type for the kamacore fetch front end.
package kamacore_pkg;
  localparam int KC_ADDR_WIDTH = 8;
  localparam int KC_CPU_WIDTH  = 32;
  localparam int KC_RESET_PC   = 0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/kamacore_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module kamacore_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/kamacore_fetch_ctrl.sv
// PC sequencer and IF/ID register with branch squash, stall and halt/resume.
// Define KAMACORE_FETCH_PERF_EN to add fetched/bubble performance counters.
module kamacore_fetch_ctrl
  import kamacore_pkg::*;
#(
  parameter int ADDR_WIDTH = KC_ADDR_WIDTH,
  parameter int CPU_WIDTH  = KC_CPU_WIDTH,
  parameter int RESET_PC   = KC_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0]  imem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [CPU_WIDTH-1:0]  if_instruction,
  output logic                  halted
`ifdef KAMACORE_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);
  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [CPU_WIDTH-1:0]  if_instr_q, if_instr_d;
  logic                  halted_q, halted_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    halted_d   = halted_q;
    unique case (state_q)
      BOOT: begin
        if (halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A redirect squashes the word already fetched even under stall.
        if (branch_valid) begin
          pc_d       = branch_target;
          if_valid_d = 1'b0;
        end else if (halt) begin
          state_d    = HALT;
          halted_d   = 1'b1;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_WIDTH'(1);
        end
      end
      HALT: begin
        if (branch_valid) begin
          pc_d = branch_target;
        end
        if (resume && !halt) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign halted         = halted_q;

`ifdef KAMACORE_FETCH_PERF_EN
  logic in_run;
  logic fetch_inc;
  logic bubble_inc;

  assign in_run     = (state_q == RUN);
  assign fetch_inc  = in_run && !branch_valid && !halt && !stall;
  assign bubble_inc = in_run && (branch_valid || halt);

  kamacore_sat_counter #(.WIDTH(32)) u_fetched_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (fetch_inc),
    .count (perf_fetched)
  );

  kamacore_sat_counter #(.WIDTH(32)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (bubble_inc),
    .count (perf_bubbles)
  );
`endif
endmodule

// File: tb/tb_kamacore_fetch_ctrl.sv
// Self-checking bench for kamacore_fetch_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model of the fetch rules.
module tb_kamacore_fetch_ctrl;
  localparam int AW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          resume;
  logic [AW-1:0] imem_addr;
  logic [CW-1:0] imem_rdata;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [CW-1:0] if_instruction;
  logic          halted;
`ifdef KAMACORE_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_bubbles;
`endif

  always #5 clk = ~clk;

  logic [CW-1:0] imem [0:255];
  assign imem_rdata = imem[imem_addr];

  kamacore_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .halt           (halt),
    .resume         (resume),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .halted         (halted)
`ifdef KAMACORE_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  // Model: mode 0 = booting, 1 = fetching, 2 = halted.
  int            m_mode;
  int            m_pc;
  int            m_ipc;
  logic [CW-1:0] m_ins;
  logic          m_v;
  logic          m_h;
  longint        m_fetched;
  longint        m_bub;
  int            cyc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_ins = '0; m_v = 0; m_h = 0;
      m_fetched = 0; m_bub = 0;
    end else if (m_mode == 0) begin
      m_mode = halt ? 2 : 1;
      m_h    = halt;
    end else if (m_mode == 1) begin
      if (branch_valid) begin
        m_pc = int'(branch_target); m_v = 0; m_bub++;
      end else if (halt) begin
        m_mode = 2; m_v = 0; m_h = 1; m_bub++;
      end else if (!stall) begin
        m_ins = imem[m_pc]; m_ipc = m_pc; m_v = 1;
        m_pc = (m_pc + 1) % 256;
        m_fetched++;
      end
    end else begin
      if (branch_valid) m_pc = int'(branch_target);
      if (resume && !halt) begin
        m_mode = 1; m_h = 0;
      end
    end
    if (m_fetched > 64'hFFFF_FFFF) m_fetched = 64'hFFFF_FFFF;
    if (m_bub > 64'hFFFF_FFFF) m_bub = 64'hFFFF_FFFF;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%0b br=%0b tgt=%02h st=%0b h=%0b r=%0b | v=%0b pc=%02h ins=%08h hl=%0b addr=%02h",
             cyc, rst, branch_valid, branch_target, stall, halt, resume,
             if_valid, if_pc, if_instruction, halted, imem_addr);
    chk("if_valid", 64'(if_valid), 64'(m_v));
    chk("if_pc", 64'(if_pc), 64'(m_ipc));
    chk("if_instruction", 64'(if_instruction), 64'(m_ins));
    chk("halted", 64'(halted), 64'(m_h));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
`ifdef KAMACORE_FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
`endif
  endtask

  task automatic drive(input logic r, input logic st, input logic br, input logic [AW-1:0] tgt,
                       input logic h, input logic rs);
    rst = r; stall = st; branch_valid = br; branch_target = tgt; halt = h; resume = rs;
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000 + i;
    drive(1, 0, 0, '0, 0, 0);
    tick();
    tick();
    chk("reset_valid", 64'(if_valid), 64'd0);
    chk("reset_pc", 64'(if_pc), 64'd0);

    // Boot and free run: first valid output two cycles after reset release.
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("boot_invalid", 64'(if_valid), 64'd0);
    tick();
    chk("first_valid", 64'(if_valid), 64'd1);
    chk("first_pc", 64'(if_pc), 64'd0);
    chk("first_instr", 64'(if_instruction), 64'h1000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", 64'(if_pc), 64'(i));
    end

    // Branch from pc 0x05 to 0x40.
    chk("pre_branch_addr", 64'(imem_addr), 64'h05);
    drive(0, 0, 1, 8'h40, 0, 0);
    tick();
    chk("branch_squash", 64'(if_valid), 64'd0);
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("branch_target_pc", 64'(if_pc), 64'h40);
    chk("branch_target_ins", 64'(if_instruction), 64'h1040);
`ifdef KAMACORE_FETCH_PERF_EN
    chk("perf_bubbles_s2", 64'(perf_bubbles), 64'd1);
`endif

    // Stall holding if_pc 0x10.
    drive(0, 0, 1, 8'h10, 0, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0);
    tick();
    drive(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", 64'(if_pc), 64'h10);
      chk("stall_hold_v", 64'(if_valid), 64'd1);
    end
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("stall_release_pc", 64'(if_pc), 64'h11);

    // Branch beats stall.
    drive(0, 1, 1, 8'h20, 0, 0);
    tick();
    chk("flush_over_stall", 64'(if_valid), 64'd0);
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("flush_target_pc", 64'(if_pc), 64'h20);

    // Halt at pc 0x08, resume later; halt+resume together stays halted.
    drive(0, 0, 1, 8'h08, 0, 0);
    tick();
    drive(0, 0, 0, '0, 1, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_hold", 64'(halted), 64'd1);
    end
    drive(0, 0, 0, '0, 1, 1);
    tick();
    chk("halt_and_resume", 64'(halted), 64'd1);
    drive(0, 0, 0, '0, 0, 1);
    tick();
    chk("resumed", 64'(halted), 64'd0);
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("resume_pc", 64'(if_pc), 64'h08);

    // PC wrap at the top of the address space.
    drive(0, 0, 1, 8'hFE, 0, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0);
    tick();
    chk("wrap_fe", 64'(if_pc), 64'hFE);
    tick();
    chk("wrap_ff", 64'(if_pc), 64'hFF);
    tick();
    chk("wrap_00", 64'(if_pc), 64'h00);

    // Mid-stream reset.
    drive(1, 0, 1, 8'h33, 1, 0);
    tick();
    chk("midrst_valid", 64'(if_valid), 64'd0);
    chk("midrst_pc", 64'(if_pc), 64'd0);
    chk("midrst_ins", 64'(if_instruction), 64'd0);
    chk("midrst_halted", 64'(halted), 64'd0);

    // Random traffic with fresh memory contents.
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    for (int n = 0; n < 700; n++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 25), ($urandom_range(99) < 8),
            AW'($urandom_range(255)), ($urandom_range(99) < 6), ($urandom_range(99) < 25));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kamacore_fetch_ctrl.md
Name: kamacore_fetch_ctrl

Overview:
Sequences the program counter and the instruction-fetch pipeline register in front of the instruction memory. Handles reset boot, branch redirect with wrong-path squash, downstream stall, and halt/resume. It drives the combinational-read instruction memory address and presents {valid, pc, instruction} to the IF/ID boundary.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width (PC width)
CPU_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall  input  1  downstream hazard stall; hold PC and IF/ID outputs
branch_valid  input  1  redirect request from EX, one-cycle pulse
branch_target  input  ADDR_WIDTH  redirect PC, sampled when branch_valid=1
halt  input  1  enter HALT state
resume  input  1  leave HALT state
imem_addr  output  ADDR_WIDTH  instruction memory read address; equals current PC
imem_rdata  input  CPU_WIDTH  instruction memory combinational read data
if_valid  output  1  IF/ID slot holds a real instruction
if_pc  output  ADDR_WIDTH  PC of if_instruction
if_instruction  output  CPU_WIDTH  fetched instruction
halted  output  1  high while in HALT

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=BOOT, if_valid=0, if_pc=0, if_instruction=0, halted=0. Reset overrides every other input, including mid-branch and mid-halt.
- imem_addr = pc (combinational). imem_rdata is valid in the same cycle.
- States (fetch_state_t):
  - BOOT: lasts one cycle. Outputs stay invalid and pc holds. Goes to RUN unconditionally, unless halt=1, in which case it goes to HALT.
  - RUN: normal fetch.
  - HALT: pc frozen, if_valid=0, halted=1. Goes to RUN when resume=1 and halt=0. If resume=1 and halt=1 in the same cycle, it stays in HALT.
- RUN priority per cycle: branch_valid > halt > stall > advance.
  - branch_valid: pc<=branch_target; if_valid<=0 to squash the wrong-path word at the old pc. This applies even when stall=1, so a flush overrides a stall. The first target instruction appears with if_valid=1 two cycles after the branch cycle.
  - halt (no branch): go to HALT; if_valid<=0; pc holds, so the un-issued word at pc is refetched on resume.
  - stall (no branch/halt): pc, if_valid, if_pc and if_instruction all hold.
  - advance: if_instruction<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
- Branch while in HALT: pc<=branch_target, state stays HALT.
- PC arithmetic is modulo 2^ADDR_WIDTH: the pc at all-ones wraps to 0 with no flag.
- Latency: an instruction at pc fetched in cycle t is visible on the IF/ID outputs in cycle t+1.

Optional Feature:
KAMACORE_FETCH_PERF_EN
- Defined: adds output ports perf_fetched[31:0] and perf_bubbles[31:0].
  - perf_fetched increments on each advance cycle.
  - perf_bubbles increments on each cycle in RUN where if_valid is written to 0 (branch squash, halt entry).
  - Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- kamacore_pkg holds ADDR_WIDTH, CPU_WIDTH and RESET_PC defaults, plus the fetch_state_t enum {BOOT, RUN, HALT}.
- One sub-module, kamacore_sat_counter (parameter WIDTH, with inc and clear inputs), instantiated twice under KAMACORE_FETCH_PERF_EN.
- Next-PC selection and output-register logic stay inline.

Test Plan:
1. Reset then free run, imem[i]=0x1000+i: if_valid first rises 2 cycles after rst falls, with if_pc=0, instr=0x1000; the next cycles show pc 1, 2, 3 consecutively.
2. branch_valid=1, branch_target=0x40, while pc=0x05: the next output has if_valid=0; the cycle after shows if_pc=0x40, instr=imem[0x40]; no output ever has if_pc=0x05.
3. stall=1 for 3 cycles with if_pc=0x10 held: outputs stay constant for 3 cycles; after release if_pc=0x11 follows with no skipped or duplicated pc.
4. Branch with stall=1 in the same cycle, target=0x20: the squash occurs (if_valid=0) and the next valid output is if_pc=0x20.
5. halt at pc=0x08, then resume 4 cycles later: halted=1 for 4 cycles; the first valid output after resume is if_pc=0x08. halt and resume together keep halted=1.
6. ADDR_WIDTH=8, run from pc=0xFE: if_pc sequence is 0xFE, 0xFF, 0x00. rst asserted mid-stream zeroes all outputs the next cycle. With KAMACORE_FETCH_PERF_EN, after scenario 2: perf_bubbles=1.
